// File: rtl/tdm_pair_demux.sv
// -----------------------------------------------------------------------------
// tdm_pair_demux
//
// Two-channel time-division demultiplexer. It takes a single tagged word stream
// in which channel A (sel=0) and channel B (sel=1) words alternate. It rebuilds
// each A/B pair into parallel registered outputs and flags framing violations.
//
// Optional feature macro: TDM_PAIR_DEMUX_ERRCNT_EN
//   defined     : err_count_o counts frame_err pulses and saturates at 255
//   not defined : err_count_o is tied to zero
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   in_valid_i   in_sel_i/in_data_i carry a word this cycle
//   in_sel_i     channel tag, 0 = A, 1 = B
//   in_data_i    channel word
//   a_out_o      A word of the last completed pair
//   b_out_o      B word of the last completed pair
//   out_valid_o  one-cycle pulse, a new pair is on a_out_o/b_out_o
//   frame_err_o  one-cycle pulse, a sequence violation was sampled
//   busy_o       high while an A word is held and a B word is awaited
//   err_count_o  saturating violation count
// -----------------------------------------------------------------------------
module tdm_pair_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_sel_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic [WIDTH-1:0] a_out_o,
  output logic [WIDTH-1:0] b_out_o,
  output logic             out_valid_o,
  output logic             frame_err_o,
  output logic             busy_o,
  output logic [7:0]       err_count_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_HAVE_A = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_hold_q,    a_hold_d;
  logic [WIDTH-1:0] a_out_q,     a_out_d;
  logic [WIDTH-1:0] b_out_q,     b_out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q,      busy_d;

  // Next-state and output decode for the pairing FSM.
  always_comb begin
    state_d     = state_q;
    a_hold_d    = a_hold_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (in_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_sel_i) begin
            a_hold_d = in_data_i;
            state_d  = ST_HAVE_A;
          end else begin
            // B without a preceding A: drop it.
            frame_err_d = 1'b1;
          end
        end
        ST_HAVE_A: begin
          if (in_sel_i) begin
            // Both halves load together so the pair is never seen half-updated.
            a_out_d     = a_hold_q;
            b_out_d     = in_data_i;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            // Second A in a row: resync onto the newest A.
            a_hold_d    = in_data_i;
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == ST_HAVE_A);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      a_hold_q    <= {WIDTH{1'b0}};
      a_out_q     <= {WIDTH{1'b0}};
      b_out_q     <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_hold_q    <= a_hold_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef TDM_PAIR_DEMUX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating count of framing violations, updated on the same edge as frame_err.
  always_comb begin
    err_count_d = err_count_q;
    if (frame_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Violation counter register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count_o = err_count_q;
`else
  assign err_count_o = 8'd0;
`endif

  assign a_out_o     = a_out_q;
  assign b_out_o     = b_out_q;
  assign out_valid_o = out_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_tdm_pair_demux.sv
// Directed testbench for tdm_pair_demux.
module tb_tdm_pair_demux;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_sel_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic [7:0] a_out_o, b_out_o, err_count_o;
  logic       out_valid_o, frame_err_o, busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  // {a_out, b_out, out_valid, frame_err, busy}
  logic [18:0] obs;
  assign obs = {a_out_o, b_out_o, out_valid_o, frame_err_o, busy_o};

  tdm_pair_demux #(.WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_sel_i   (in_sel_i),
    .in_data_i  (in_data_i),
    .a_out_o    (a_out_o),
    .b_out_o    (b_out_o),
    .out_valid_o(out_valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o),
    .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one input word, clock it in, and settle 1 time unit after the edge.
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid_i = v;
    in_sel_i   = s;
    in_data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (obs !== 19'd0 || err_count_o !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state obs=%h err=%0d expected obs=0 err=0", obs, err_count_o);
    end
    drive(1'b1, 1'b0, 8'h55);
    tests_run++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_pre_a obs=%h expected busy only", obs);
    end
    // Asynchronous assertion between edges.
    #2;
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (obs !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_async obs=%h expected 0", obs);
    end
    #1;
    rst_i = 1'b0;
    drive(1'b1, 1'b1, 8'h11);
    tests_run++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_b_first obs=%h expected frame_err only", obs);
    end
    drive(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (obs !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_err_pulse_end obs=%h expected 0", obs);
    end
  endtask

  task automatic test_normal_pair();
    drive(1'b1, 1'b0, 8'h3C);
    tests_run++;
    if (obs !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL normal_a obs=%h expected busy", obs);
    end
    drive(1'b1, 1'b1, 8'hA5);
    tests_run++;
    if (obs !== {8'h3C, 8'hA5, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL normal_pair obs=%h expected %h", obs, {8'h3C, 8'hA5, 3'b100});
    end
    drive(1'b0, 1'b1, 8'hFF);
    tests_run++;
    if (obs !== {8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL normal_hold obs=%h expected %h", obs, {8'h3C, 8'hA5, 3'b000});
    end
  endtask

  task automatic test_gapped_pair();
    drive(1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'hEE);
      tests_run++;
      if (obs !== {8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL gapped_wait%0d obs=%h expected %h", i, obs, {8'h3C, 8'hA5, 3'b001});
      end
    end
    drive(1'b1, 1'b1, 8'h02);
    tests_run++;
    if (obs !== {8'h01, 8'h02, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL gapped_pair obs=%h expected %h", obs, {8'h01, 8'h02, 3'b100});
    end
  endtask

  task automatic test_double_a();
    drive(1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 8'h20);
    tests_run++;
    if (obs !== {8'h01, 8'h02, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL double_a_err obs=%h expected %h", obs, {8'h01, 8'h02, 3'b011});
    end
    drive(1'b1, 1'b1, 8'h30);
    tests_run++;
    if (obs !== {8'h20, 8'h30, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL double_a_pair obs=%h expected %h", obs, {8'h20, 8'h30, 3'b100});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa, pb, va, vb;
    pa = 8'h20;
    pb = 8'h30;
    for (int k = 0; k < 4; k++) begin
      va = 8'(2 * k);
      vb = 8'(2 * k + 1);
      drive(1'b1, 1'b0, va);
      tests_run++;
      if (obs !== {pa, pb, 1'b0, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL stream_a%0d obs=%h expected %h", k, obs, {pa, pb, 3'b001});
      end
      drive(1'b1, 1'b1, vb);
      tests_run++;
      if (obs !== {va, vb, 1'b1, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL stream_pair%0d obs=%h expected %h", k, obs, {va, vb, 3'b100});
      end
      pa = va;
      pb = vb;
    end
  endtask

  task automatic test_err_count();
    int fe_seen;
    logic [7:0] exp_cnt;
`ifdef TDM_PAIR_DEMUX_ERRCNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    apply_reset();
    fe_seen = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      if (frame_err_o === 1'b1 && out_valid_o === 1'b0) fe_seen++;
    end
    tests_run++;
    if (fe_seen !== 300) begin
      tests_failed++;
      $display("FAIL errcnt_pulses got=%0d expected=300", fe_seen);
    end
    tests_run++;
    if (err_count_o !== exp_cnt || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL errcnt_value got=%0d busy=%b expected=%0d busy=0", err_count_o, busy_o, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_normal_pair();
    test_gapped_pair();
    test_double_a();
    test_back_to_back();
    test_err_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
